// File: rtl/lcd_scroll_ctrl_if.sv
// Control and status bundle between the scroll sequencer and its user.
// There is no handshake here: the control inputs are plain levels,
// except next_msg, which is a single-cycle request pulse. step and wrap
// are single-cycle strobes that are never held and cannot be stalled.
// A consumer that wants an event must sample the strobe in the cycle
// it is high.
interface lcd_scroll_ctrl_if;
    logic       enable;
    logic       pause;
    logic       auto_adv;
    logic       next_msg;
    logic [5:0] msg_len;
    logic [4:0] shift_pos;
    logic [1:0] msg_sel;
    logic       step;
    logic       wrap;
    logic [1:0] state;

    // The controlling side drives the inputs and observes the position outputs.
    modport master (
        output enable, pause, auto_adv, next_msg, msg_len,
        input  shift_pos, msg_sel, step, wrap, state
    );

    // The sequencer receives the inputs and drives the position outputs.
    modport slave (
        input  enable, pause, auto_adv, next_msg, msg_len,
        output shift_pos, msg_sel, step, wrap, state
    );
endinterface

// File: rtl/lcd_scroll_ctrl.sv
// Scroll sequencer for the 16x2 character display.
// A prescaler divides clk into scroll steps. Each message dwells at
// position 0 for HOLD_STEPS steps and then scrolls until it wraps.
// The block supports pause, manual skip and auto-advance on wrap.
// All outputs are registered.
module lcd_scroll_ctrl #(
    parameter int TICK_DIV   = 12_500_000,
    parameter int HOLD_STEPS = 8,
    parameter int NUM_MSG    = 4
) (
    input  logic               clk,
    input  logic               rst,
    lcd_scroll_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SCROLL = 2'd2,
        PAUSED = 2'd3
    } state_t;

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_STEPS + 1);

    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [1:0]    MSG_LAST  = 2'(NUM_MSG - 1);

    state_t        state_q, state_d;
    state_t        saved_q, saved_d;
    state_t        eff_state;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [4:0]    pos_q, pos_d;
    logic [1:0]    msg_q, msg_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;

    logic          tick;
    logic [5:0]    len_eff;
    logic [5:0]    pos_inc;
    logic [1:0]    msg_next;

    // A length of 0, or one longer than the line buffer, scrolls the full 32 characters.
    always_comb begin
        len_eff  = 6'd32;
        pos_inc  = {1'b0, pos_q} + 6'd1;
        msg_next = (msg_q == MSG_LAST) ? 2'd0 : msg_q + 2'd1;
        if (bus.msg_len != 6'd0 && bus.msg_len <= 6'd32) begin
            len_eff = bus.msg_len;
        end
    end

    // Register every piece of state, including the registered output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            saved_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            pos_q   <= '0;
            msg_q   <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            pos_q   <= pos_d;
            msg_q   <= msg_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state logic, in priority order: enable, next_msg, pause, tick.
    // On the first unpaused cycle, PAUSED behaves exactly like its saved
    // state. The prescaler therefore resumes counting in that same cycle,
    // and a tick that was frozen at the last count fires immediately.
    always_comb begin
        state_d   = state_q;
        saved_d   = saved_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        pos_d     = pos_q;
        msg_d     = msg_q;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        tick      = 1'b0;
        eff_state = (state_q == PAUSED) ? saved_q : state_q;

        if (!bus.enable) begin
            state_d = IDLE;
            pos_d   = '0;
            cnt_d   = '0;
            hold_d  = '0;
        end else if (state_q == IDLE) begin
            state_d = HOLD;
            cnt_d   = '0;
            hold_d  = '0;
        end else if (bus.next_msg) begin
            msg_d   = msg_next;
            pos_d   = '0;
            state_d = HOLD;
            cnt_d   = '0;
            hold_d  = '0;
        end else if (bus.pause) begin
            state_d = PAUSED;
            saved_d = eff_state;
        end else begin
            state_d = eff_state;
            tick    = (cnt_q == TICK_LAST);
            cnt_d   = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                case (eff_state)
                    HOLD: begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d = '0;
                            step_d = 1'b1;
                            if (len_eff == 6'd1) begin
                                pos_d   = '0;
                                wrap_d  = 1'b1;
                                state_d = HOLD;
                                if (bus.auto_adv) msg_d = msg_next;
                            end else begin
                                pos_d   = 5'd1;
                                state_d = SCROLL;
                            end
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    SCROLL: begin
                        step_d = 1'b1;
                        if (pos_inc >= len_eff) begin
                            pos_d   = '0;
                            wrap_d  = 1'b1;
                            state_d = HOLD;
                            hold_d  = '0;
                            if (bus.auto_adv) msg_d = msg_next;
                        end else begin
                            pos_d = pos_inc[4:0];
                        end
                    end
                    default: begin
                        state_d = eff_state;
                    end
                endcase
            end
        end
    end

    assign bus.shift_pos = pos_q;
    assign bus.msg_sel   = msg_q;
    assign bus.step      = step_q;
    assign bus.wrap      = wrap_q;
    assign bus.state     = state_q;

endmodule
